// File: rtl/column_scan_buffer_pkg.sv
// Shared types for the POV slice buffer: pixel/column containers and the scan FSM states.
package pov_pkg;

    localparam int NUM_ROWS_DEF  = 64;
    localparam int SCAN_RATE_DEF = 32;
    localparam int PIX_W_DEF     = 3;

    typedef logic [PIX_W_DEF-1:0]      pixel_t;
    typedef pixel_t [NUM_ROWS_DEF-1:0] column_t;
    typedef column_t [1:0]             col_pair_t;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/column_scan_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head is visible on dout while valid.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push at full is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (PTR_W+1)'(DEPTH)) || do_pop);
    assign valid   = (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/column_scan_buffer.sv
// Per-slice column fetcher for the rotating HUB75 POV panel with FIFO output and overrun flag.
// COL_MASK_SKIP_EN: when defined, col_mask_in skips unlit scan lines; otherwise every line is fetched.
//
// state | meaning
// IDLE  | waiting for a new theta (or first slice after reset)
// LATCH | capture theta, mask, mode and last lit line
// SCAN  | walk scan lines, issue source reads under FIFO credit
// DRAIN | wait for outstanding source reads to land
// DONE  | pulse slice_done_out
module column_scan_buffer
    import pov_pkg::*;
#(
    parameter int NUM_ROWS    = NUM_ROWS_DEF,
    parameter int SCAN_RATE   = SCAN_RATE_DEF,
    parameter int THETA_RES   = 8,
    parameter int NUM_SOURCES = 2,
    parameter int PIX_W       = PIX_W_DEF,
    parameter int SRC_LAT     = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n_in,
    input  logic [$clog2(NUM_SOURCES)-1:0]          mode_in,
    input  logic [THETA_RES-1:0]                    theta_in,
    input  logic [SCAN_RATE-1:0]                    col_mask_in,
    output logic [THETA_RES-1:0]                    src_theta_out,
    output logic [$clog2(SCAN_RATE)-1:0]            src_col_num1_out,
    output logic [$clog2(SCAN_RATE):0]              src_col_num2_out,
    input  logic [NUM_SOURCES*2*NUM_ROWS*PIX_W-1:0] src_cols_in,
    output logic                                    col_valid_out,
    input  logic                                    col_ready_in,
    output logic [$clog2(SCAN_RATE)-1:0]            col_idx_out,
    output logic [2*NUM_ROWS*PIX_W-1:0]             col_data_out,
    output logic                                    col_last_out,
    output logic                                    slice_done_out,
    output logic                                    overrun_out
);

    localparam int IDX_W  = $clog2(SCAN_RATE);
    localparam int MODE_W = $clog2(NUM_SOURCES);
    localparam int PAIR_W = 2*NUM_ROWS*PIX_W;
    localparam int ENT_W  = IDX_W + 1 + PAIR_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W  = $clog2(FIFO_DEPTH + SRC_LAT + 1) + 1;

    scan_state_t          state;
    logic [THETA_RES-1:0] theta_q;
    logic [SCAN_RATE-1:0] mask_q;
    logic [MODE_W-1:0]    mode_q;
    logic [IDX_W-1:0]     last_q;
    logic                 primed;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W:0]       col_num2;
    logic                 overrun;
    logic                 slice_done;

    logic [SCAN_RATE-1:0] mask_eff;
    logic [IDX_W-1:0]     hi_idx;
    logic                 abort;
    logic                 credit_ok;
    logic                 issue;
    logic [SUM_W-1:0]     inflight;
    logic                 tail_vld;
    logic [IDX_W-1:0]     tail_idx;
    logic                 push;
    logic                 pop;
    logic [PAIR_W-1:0]    src_arr [NUM_SOURCES];
    logic [PAIR_W-1:0]    src_sel;
    logic [ENT_W-1:0]     head;
    logic                 head_valid;
    logic [CNT_W-1:0]     fifo_count;

`ifdef COL_MASK_SKIP_EN
    assign mask_eff = col_mask_in;
`else
    logic unused_mask;
    assign mask_eff    = '1;
    assign unused_mask = ^col_mask_in;
`endif

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < SCAN_RATE; i++) begin
            if (mask_eff[i]) hi_idx = IDX_W'(i);
        end
    end

    // Credit counts reads still in the source pipe so a landing result always has a slot.
    assign abort     = ((state == SCAN) || (state == DRAIN)) && (theta_in != theta_q);
    assign credit_ok = (SUM_W'(fifo_count) + inflight) < SUM_W'(FIFO_DEPTH);
    assign issue     = (state == SCAN) && !abort && mask_q[idx] && credit_ok;

    generate
        if (SRC_LAT == 0) begin : g_comb_src
            assign tail_vld = issue;
            assign tail_idx = idx;
            assign inflight = '0;
        end else begin : g_pipe_src
            logic [SRC_LAT-1:0] pipe_vld;
            logic [IDX_W-1:0]   pipe_idx [SRC_LAT];

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    pipe_vld <= '0;
                    for (int i = 0; i < SRC_LAT; i++) pipe_idx[i] <= '0;
                end else begin
                    pipe_vld[0] <= issue;
                    pipe_idx[0] <= idx;
                    for (int i = 1; i < SRC_LAT; i++) begin
                        pipe_vld[i] <= pipe_vld[i-1];
                        pipe_idx[i] <= pipe_idx[i-1];
                    end
                    if (abort) pipe_vld <= '0;
                end
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < SRC_LAT; i++) inflight = inflight + SUM_W'(pipe_vld[i]);
            end

            assign tail_vld = pipe_vld[SRC_LAT-1];
            assign tail_idx = pipe_idx[SRC_LAT-1];
        end
    endgenerate

    always_comb begin
        for (int s = 0; s < NUM_SOURCES; s++) src_arr[s] = src_cols_in[s*PAIR_W +: PAIR_W];
        src_sel = src_arr[mode_q];
    end

    assign push = tail_vld && !abort;
    assign pop  = head_valid && col_ready_in;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push     (push),
        .din      ({tail_idx, (tail_idx == last_q), src_sel}),
        .pop      (pop),
        .dout     (head),
        .valid    (head_valid),
        .count    (fifo_count)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            theta_q    <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            last_q     <= '0;
            primed     <= 1'b0;
            idx        <= '0;
            col_num2   <= '0;
            overrun    <= 1'b0;
            slice_done <= 1'b0;
        end else begin
            slice_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!primed || (theta_in != theta_q)) state <= LATCH;
                end
                LATCH: begin
                    theta_q  <= theta_in;
                    mask_q   <= mask_eff;
                    mode_q   <= mode_in;
                    last_q   <= hi_idx;
                    primed   <= 1'b1;
                    idx      <= '0;
                    col_num2 <= (IDX_W+1)'(SCAN_RATE);
                    state    <= SCAN;
                end
                SCAN: begin
                    if (abort) begin
                        overrun <= 1'b1;
                        state   <= LATCH;
                    end else if (!mask_q[idx] || credit_ok) begin
                        if (idx == IDX_W'(SCAN_RATE-1)) begin
                            state <= DRAIN;
                        end else begin
                            idx      <= idx + 1'b1;
                            col_num2 <= {1'b0, idx} + (IDX_W+1)'(SCAN_RATE + 1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        overrun <= 1'b1;
                        state   <= LATCH;
                    end else if (inflight == '0) begin
                        slice_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign src_theta_out    = theta_q;
    assign src_col_num1_out = idx;
    assign src_col_num2_out = col_num2;
    assign slice_done_out   = slice_done;
    assign overrun_out      = overrun;
    assign col_valid_out    = head_valid;
    assign col_idx_out      = head_valid ? head[ENT_W-1 -: IDX_W] : '0;
    assign col_last_out     = head_valid ? head[PAIR_W] : 1'b0;
    assign col_data_out     = head_valid ? head[PAIR_W-1:0] : '0;

endmodule

// File: tb/tb_column_scan_buffer.sv
// Scoreboard bench for column_scan_buffer: random slices against a list-based slice model.
module tb_column_scan_buffer;

    localparam int NUM_ROWS    = 64;
    localparam int SCAN_RATE   = 32;
    localparam int THETA_RES   = 8;
    localparam int NUM_SOURCES = 2;
    localparam int PIX_W       = 3;
    localparam int SRC_LAT     = 1;
    localparam int FIFO_DEPTH  = 8;
    localparam int PAIR_W      = 2*NUM_ROWS*PIX_W;

    typedef struct {
        logic [4:0]        idx;
        logic [PAIR_W-1:0] data;
        logic              last;
    } exp_t;

    logic                              clk_in;
    logic                              rst_n_in;
    logic [0:0]                        mode_in;
    logic [7:0]                        theta_in;
    logic [31:0]                       col_mask_in;
    logic [7:0]                        src_theta_out;
    logic [4:0]                        src_col_num1_out;
    logic [5:0]                        src_col_num2_out;
    logic [NUM_SOURCES*PAIR_W-1:0]     src_cols_in;
    logic                              col_valid_out;
    logic                              col_ready_in;
    logic [4:0]                        col_idx_out;
    logic [PAIR_W-1:0]                 col_data_out;
    logic                              col_last_out;
    logic                              slice_done_out;
    logic                              overrun_out;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   done_cnt;
    int   done_base;
    int   ready_mode;
    logic [7:0] last_theta;
    logic [4:0] src_col_q;
    logic [7:0] src_th_q;

    column_scan_buffer #(
        .NUM_ROWS(NUM_ROWS), .SCAN_RATE(SCAN_RATE), .THETA_RES(THETA_RES),
        .NUM_SOURCES(NUM_SOURCES), .PIX_W(PIX_W), .SRC_LAT(SRC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .mode_in(mode_in), .theta_in(theta_in),
        .col_mask_in(col_mask_in), .src_theta_out(src_theta_out),
        .src_col_num1_out(src_col_num1_out), .src_col_num2_out(src_col_num2_out),
        .src_cols_in(src_cols_in), .col_valid_out(col_valid_out), .col_ready_in(col_ready_in),
        .col_idx_out(col_idx_out), .col_data_out(col_data_out), .col_last_out(col_last_out),
        .slice_done_out(slice_done_out), .overrun_out(overrun_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [PAIR_W-1:0] pat(input int s, input int col, input logic [7:0] th);
        logic [31:0] w;
        w = {th, 8'(s), 8'(col), 8'hA5} ^ (32'(col) * 32'h9E3779B1) ^ (32'(s) * 32'h85EBCA77);
        return {12{w}};
    endfunction

    function automatic logic [31:0] eff_mask(input logic [31:0] m);
`ifdef COL_MASK_SKIP_EN
        return m;
`else
        return (m | ~m);
`endif
    endfunction

    // Pattern sources: one-cycle registered read of the requested column.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            src_col_q <= '0;
            src_th_q  <= '0;
        end else begin
            src_col_q <= src_col_num1_out;
            src_th_q  <= src_theta_out;
        end
    end
    assign src_cols_in = {pat(1, int'(src_col_q), src_th_q), pat(0, int'(src_col_q), src_th_q)};

    initial begin
        col_ready_in = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (ready_mode == 1)      col_ready_in = 1'b1;
            else if (ready_mode == 2) col_ready_in = 1'($urandom_range(0, 1));
            else                      col_ready_in = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head is compared against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && slice_done_out) done_cnt++;
            if (rst_n_in && col_valid_out && col_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got idx %0d expected no entry", col_idx_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("col_idx", 64'(col_idx_out), 64'(e.idx));
                    chk("col_last", 64'(col_last_out), 64'(e.last));
                    checks++;
                    if (col_data_out !== e.data) begin
                        errors++;
                        $display("FAIL col_data idx %0d: got %h expected %h", e.idx, col_data_out, e.data);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] next_theta();
        logic [7:0] t;
        do t = 8'($urandom_range(1, 255)); while (t == last_theta);
        last_theta = t;
        return t;
    endfunction

    task automatic push_slice(input logic [7:0] th, input int md, input logic [31:0] msk, input int limit);
        logic [31:0] m;
        int   hi;
        exp_t e;
        m  = eff_mask(msk);
        hi = -1;
        for (int i = 0; i < SCAN_RATE; i++) if (m[i]) hi = i;
        for (int i = 0; i < limit; i++) begin
            if (m[i]) begin
                e.idx  = 5'(i);
                e.data = pat(md, i, th);
                e.last = (i == hi);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_slice(input logic [7:0] th, input int md, input logic [31:0] msk, input int limit);
        push_slice(th, md, msk, limit);
        theta_in    = th;
        mode_in     = 1'(md);
        col_mask_in = msk;
        done_base   = done_cnt;
    endtask

    task automatic wait_theta(input logic [7:0] th);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (src_theta_out !== th && n < 20);
        chk("slice_theta_latched", 64'(src_theta_out), 64'(th));
    endtask

    // Called at the first scan cycle: check request start, then disturb latched inputs.
    task automatic seen_start(input int md);
        chk("first_col_num1", 64'(src_col_num1_out), 64'd0);
        chk("first_col_num2", 64'(src_col_num2_out), 64'(SCAN_RATE));
        mode_in     = 1'(~md);
        col_mask_in = $urandom;
    endtask

    task automatic finish_slice(input int exp_cycles);
        int n;
        n = 0;
        while (slice_done_out !== 1'b1 && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        if (exp_cycles >= 0) chk("slice_done_timing", 64'(n), 64'(exp_cycles));
        else                 chk("slice_done_seen", 64'(slice_done_out), 64'd1);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (exp_q.size() != 0 && n < 3000);
        chk("slice_drained", 64'(exp_q.size()), 64'd0);
        chk("slice_done_once", 64'(done_cnt - done_base), 64'd1);
    endtask

    function automatic int lat_after(input logic [31:0] msk);
        logic [31:0] m;
        m = eff_mask(msk);
        return SCAN_RATE + 1 + (m[SCAN_RATE-1] ? SRC_LAT : 0);
    endfunction

    initial begin
        logic [7:0]  th;
        logic [31:0] msk;
        int          md;
        int          n;
        checks = 0; errors = 0; done_cnt = 0; done_base = 0;
        ready_mode = 1; last_theta = 8'd5;
        rst_n_in = 1'b0; theta_in = 8'd5; mode_in = 1'b0; col_mask_in = 32'h0000_0005;
        #23;
        chk("rst_valid", 64'(col_valid_out), 64'd0);
        chk("rst_num1", 64'(src_col_num1_out), 64'd0);
        chk("rst_num2", 64'(src_col_num2_out), 64'd0);
        chk("rst_theta", 64'(src_theta_out), 64'd0);
        chk("rst_done", 64'(slice_done_out), 64'd0);
        chk("rst_overrun", 64'(overrun_out), 64'd0);
        chk("rst_data", 64'(col_data_out[63:0]), 64'd0);

        @(negedge clk_in);
        rst_n_in = 1'b1;
        start_slice(8'd5, 0, 32'h0000_0005, SCAN_RATE);
        wait_theta(8'd5);
        seen_start(0);
        finish_slice(lat_after(32'h0000_0005));

        ready_mode = 1;
        start_slice(next_theta(), 0, 32'h0, SCAN_RATE);
        wait_theta(last_theta);
        seen_start(0);
        finish_slice(lat_after(32'h0));

        start_slice(next_theta(), 1, 32'h8000_0001, SCAN_RATE);
        wait_theta(last_theta);
        seen_start(1);
        finish_slice(lat_after(32'h8000_0001));

        for (int k = 0; k < 6; k++) begin
            ready_mode = 2;
            th  = next_theta();
            md  = int'($urandom_range(0, 1));
            msk = $urandom;
            start_slice(th, md, msk, SCAN_RATE);
            wait_theta(th);
            seen_start(md);
            finish_slice(-1);
        end

        // Backpressure: nothing is accepted, so only FIFO_DEPTH reads may be issued.
        ready_mode = 0;
        start_slice(next_theta(), 1, 32'hFFFF_FFFF, SCAN_RATE);
        wait_theta(last_theta);
        seen_start(1);
        repeat (40) @(negedge clk_in);
        chk("stall_idx", 64'(src_col_num1_out), 64'(FIFO_DEPTH));
        chk("stall_num2", 64'(src_col_num2_out), 64'(FIFO_DEPTH + SCAN_RATE));
        chk("stall_valid", 64'(col_valid_out), 64'd1);
        chk("stall_no_done", 64'(done_cnt - done_base), 64'd0);
        ready_mode = 2;
        finish_slice(-1);

        // Theta moves at idx 10: reads still in the source pipe are discarded.
        ready_mode = 1;
        start_slice(next_theta(), 0, 32'hFFFF_FFFF, 10 - SRC_LAT);
        wait_theta(last_theta);
        seen_start(0);
        chk("overrun_before", 64'(overrun_out), 64'd0);
        n = 0;
        while (src_col_num1_out !== 5'd10 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        chk("abort_at_idx10", 64'(src_col_num1_out), 64'd10);
        th = next_theta();
        push_slice(th, 1, 32'hFFFF_FFFF, SCAN_RATE);
        theta_in = th; mode_in = 1'b1; col_mask_in = 32'hFFFF_FFFF;
        wait_theta(th);
        chk("overrun_after", 64'(overrun_out), 64'd1);
        seen_start(1);
        finish_slice(lat_after(32'hFFFF_FFFF));

        // Asynchronous reset in the middle of a stalled slice.
        ready_mode = 0;
        start_slice(next_theta(), 0, 32'hFFFF_FFFF, SCAN_RATE);
        wait_theta(last_theta);
        repeat (5) @(negedge clk_in);
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b0;
        #1;
        chk("midrst_valid", 64'(col_valid_out), 64'd0);
        chk("midrst_num1", 64'(src_col_num1_out), 64'd0);
        chk("midrst_theta", 64'(src_theta_out), 64'd0);
        chk("midrst_overrun", 64'(overrun_out), 64'd0);
        chk("midrst_data", 64'(col_data_out[63:0]), 64'd0);
        exp_q.delete();
        @(negedge clk_in);
        ready_mode = 1;
        rst_n_in = 1'b1;
        start_slice(8'd0, 1, 32'h0000_0F00, SCAN_RATE);
        last_theta = 8'd0;
        repeat (2) @(negedge clk_in);
        chk("post_rst_theta", 64'(src_theta_out), 64'd0);
        seen_start(1);
        finish_slice(lat_after(32'h0000_0F00));
        chk("post_rst_overrun", 64'(overrun_out), 64'd0);

        repeat (5) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
